// File: rtl/gb_pkg.sv
// Shared constants and types for the Gaussian-blur stencil generator.
package gb_pkg;

    localparam int unsigned GB_IMG_W    = 488;
    localparam int unsigned GB_IMG_H    = 648;
    localparam int unsigned GB_PIX_W    = 8;
    localparam int unsigned STENCIL_DIM = 9;
    localparam int unsigned NUM_LINES   = 8;

    typedef logic [GB_PIX_W-1:0]                            pixel_t;
    typedef logic [STENCIL_DIM*STENCIL_DIM*GB_PIX_W-1:0]    stencil_t;

endpackage

// File: rtl/gb_line_ram.sv
// One row buffer: asynchronous read, synchronous write.
module gb_line_ram #(
    parameter int unsigned DEPTH = 488,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/gb_stencil_gen.sv
// Raster-stream to 9x9 sliding-window generator with 8 rotating line buffers.
// Optional end-of-frame flag on out_last when GB_EOF_FLAG_EN is defined.
module gb_stencil_gen
    import gb_pkg::*;
#(
    parameter int unsigned IMG_W = GB_IMG_W,
    parameter int unsigned IMG_H = GB_IMG_H,
    parameter int unsigned PIX_W = GB_PIX_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PIX_W-1:0]                        in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [STENCIL_DIM*STENCIL_DIM*PIX_W-1:0] out_stencil,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned WW = $clog2(NUM_LINES);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_EDGE = XW'(STENCIL_DIM - 1);
    localparam logic [YW-1:0] Y_EDGE = YW'(STENCIL_DIM - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [WW-1:0] w;

    logic accept, qual, out_hs, x_wrap, frame_end;

    logic [PIX_W-1:0] lb_rd   [NUM_LINES];
    logic [PIX_W-1:0] new_col [STENCIL_DIM];
    logic [PIX_W-1:0] win     [STENCIL_DIM][STENCIL_DIM];

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign x_wrap    = (x == X_LAST);
    assign frame_end = x_wrap && (y == Y_LAST);
    assign qual      = accept && (x >= X_EDGE) && (y >= Y_EDGE);

    // Buffer w holds the oldest row and is overwritten by the incoming one.
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_lb
        gb_line_ram #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_ram (
            .clk   (clk),
            .we    (accept && (w == WW'(i))),
            .addr  (x),
            .wdata (in_data),
            .rdata (lb_rd[i])
        );
    end

    always_comb begin
        new_col = '{default: '0};
        for (int unsigned k = 0; k < NUM_LINES; k++) begin
            new_col[k] = lb_rd[w + WW'(k)];
        end
        new_col[STENCIL_DIM-1] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            w         <= '0;
            out_valid <= 1'b0;
            for (int unsigned r = 0; r < STENCIL_DIM; r++) begin
                for (int unsigned c = 0; c < STENCIL_DIM; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                if (x_wrap) begin
                    x <= '0;
                    if (y == Y_LAST) begin
                        y <= '0;
                        w <= '0;
                    end else begin
                        y <= y + 1'b1;
                        w <= w + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
                for (int unsigned r = 0; r < STENCIL_DIM; r++) begin
                    for (int unsigned c = 0; c < STENCIL_DIM - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][STENCIL_DIM-1] <= new_col[r];
                end
            end
            if (qual)        out_valid <= 1'b1;
            else if (out_hs) out_valid <= 1'b0;
        end
    end

    always_comb begin
        out_stencil = '0;
        for (int unsigned r = 0; r < STENCIL_DIM; r++) begin
            for (int unsigned c = 0; c < STENCIL_DIM; c++) begin
                out_stencil[(r*STENCIL_DIM + c)*PIX_W +: PIX_W] = win[r][c];
            end
        end
    end

`ifdef GB_EOF_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst)         out_last <= 1'b0;
        else if (qual)   out_last <= frame_end;
        else if (out_hs) out_last <= 1'b0;
    end
`else
    assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_gb_stencil_gen.sv
// Directed bench for gb_stencil_gen on a reduced 16x12 frame; windows checked against a ramp image model.
module tb_gb_stencil_gen;

    localparam int W    = 16;
    localparam int H    = 12;
    localparam int NPIX = W * H;
    localparam int NW   = (W - 8) * (H - 8);
    localparam int STW  = 81 * 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic [STW-1:0] out_stencil;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    int total = 0;
    int bad   = 0;

    gb_stencil_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_stencil (out_stencil),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    function automatic logic [7:0] pix(input int x, input int y, input int off);
        return 8'((x + y + off) % 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic check_window(input int k, input int off, input logic [STW-1:0] st, input logic last);
        int wx, wy, br, bc;
        logic [7:0] g, e, bg, be;
        logic exp_last;
        br = -1; bc = -1; bg = '0; be = '0;
        total++;
        if (k >= NW) begin
            bad++;
            $display("FAIL extra_window: got index %0d want below %0d", k, NW);
        end else begin
            wy = k / (W - 8) + 8;
            wx = k % (W - 8) + 8;
            for (int r = 0; r < 9; r++) begin
                for (int c = 0; c < 9; c++) begin
                    g = st[(r*9 + c)*8 +: 8];
                    e = pix(wx - 8 + c, wy - 8 + r, off);
                    if (g !== e && br < 0) begin
                        br = r; bc = c; bg = g; be = e;
                    end
                end
            end
            if (br >= 0) begin
                bad++;
                $display("FAIL window[%0d] r%0d c%0d: got %0d want %0d", k, br, bc, bg, be);
            end
        end
`ifdef GB_EOF_FLAG_EN
        exp_last = (k == NW - 1);
`else
        exp_last = 1'b0;
`endif
        chk("out_last", 32'(last), 32'(exp_last));
    endtask

    // Streams one frame; optional random in_valid and one out_ready stall.
    task automatic run_frame(input int off, input bit rnd, input int stall_at, input int stall_len,
                             output int nwin, output int nlast);
        int p, cyc, stall_left, x, y;
        bit stall_done, exp_ov, acc, hs, qual;
        logic [STW-1:0] held;
        p = 0; cyc = 0; stall_left = 0; stall_done = 0; exp_ov = 0; held = '0;
        nwin = 0; nlast = 0;
        while (1) begin
            @(negedge clk);
            if (cyc > NPIX * 4 + 200) begin
                total++; bad++;
                $display("FAIL frame_timeout: got %0d pixels want %0d", p, NPIX);
                break;
            end
            cyc++;
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (p >= NPIX && !out_valid) break;
            if (stall_at >= 0 && !stall_done && stall_left == 0 && out_valid && nwin == stall_at) begin
                stall_left = stall_len;
                stall_done = 1;
                held = out_stencil;
            end
            out_ready = (stall_left == 0);
            in_valid  = (p < NPIX) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            x = p % W;
            y = p / W;
            in_data = pix(x, y, off);
            #1;
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stall_left > 0) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                total++;
                if (out_stencil !== held) begin
                    bad++;
                    $display("FAIL stall_stable: got changed stencil want held stencil (left %0d)", stall_left);
                end
                stall_left--;
            end
            acc  = in_valid && in_ready;
            hs   = out_valid && out_ready;
            if (hs) begin
                check_window(nwin, off, out_stencil, out_last);
                if (out_last) nlast++;
                nwin++;
            end
            qual   = acc && x >= 8 && y >= 8;
            exp_ov = qual || (out_valid && !hs);
            if (acc) p++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    typedef struct {
        string name;
        int    off;
        bit    rnd;
        int    stall_at;
        int    stall_len;
        int    exp_win;
        int    exp_last;
    } frame_vec_t;

    localparam int EXP_LAST =
`ifdef GB_EOF_FLAG_EN
        1;
`else
        0;
`endif

    frame_vec_t vecs [4];
    int nwin, nlast;

    initial begin
        // Frames run back to back without reset; frame "second" checks no stale rows leak in.
        vecs[0] = '{"ramp",       0,   1'b0, -1, 0,  NW, EXP_LAST};
        vecs[1] = '{"stall",      0,   1'b0,  5, 20, NW, EXP_LAST};
        vecs[2] = '{"rand_valid", 0,   1'b1, -1, 0,  NW, EXP_LAST};
        vecs[3] = '{"second",     100, 1'b0, -1, 0,  NW, EXP_LAST};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_last",  32'(out_last),  32'd0);
        total++;
        if (out_stencil !== '0) begin
            bad++;
            $display("FAIL rst_stencil: got nonzero want 0");
        end

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].off, vecs[i].rnd, vecs[i].stall_at, vecs[i].stall_len, nwin, nlast);
            chk({vecs[i].name, "_windows"}, 32'(nwin), 32'(vecs[i].exp_win));
            chk({vecs[i].name, "_lasts"},   32'(nlast), 32'(vecs[i].exp_last));
        end

        // Partial frame up to pixel (10,6), then reset and a clean frame.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int p = 0; p < 6 * W + 10; p++) begin
            in_data = pix(p % W, p / W, 7);
            @(negedge clk);
        end
        rst = 1'b1;
        in_data = pix(10, 6, 7);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        total++;
        if (out_stencil !== '0) begin
            bad++;
            $display("FAIL midrst_stencil: got nonzero want 0");
        end
        run_frame(50, 1'b0, -1, 0, nwin, nlast);
        chk("after_rst_windows", 32'(nwin), 32'(NW));
        chk("after_rst_lasts",   32'(nlast), 32'(EXP_LAST));
        #1;
        chk("idle_out_last", 32'(out_last), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
